// File: rtl/skip_add_sequencer_if.sv
// Handshake and operand/result bundle between a wide-arithmetic client and skip_add_sequencer.
// The optional subtract request line exists only when SKIP_ADD_SEQ_SUB_EN is defined.
interface skip_add_sequencer_if #(
  parameter int OP_WIDTH = 64
);
  logic                start;
  logic [OP_WIDTH-1:0] a;
  logic [OP_WIDTH-1:0] b;
  logic                cin;
`ifdef SKIP_ADD_SEQ_SUB_EN
  logic                sub;
`endif
  logic                ready;
  logic                busy;
  logic                done;
  logic [OP_WIDTH-1:0] sum;
  logic                cout;

`ifdef SKIP_ADD_SEQ_SUB_EN
  modport master (output start, a, b, cin, sub, input ready, busy, done, sum, cout);
  modport slave  (input start, a, b, cin, sub, output ready, busy, done, sum, cout);
`else
  modport master (output start, a, b, cin, input ready, busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output ready, busy, done, sum, cout);
`endif
endinterface

// File: rtl/skip_add_sequencer.sv
// Multi-cycle wide adder: one 16-bit carry-skip adder reused over OP_WIDTH/16 cycles.
// Optional subtract mode is enabled by defining SKIP_ADD_SEQ_SUB_EN.
module skip_carry_adder (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum,
  output logic        o_cout
);
  logic [15:0] w_p;
  logic [15:0] w_g;
  logic [4:0]  w_blk_c;

  assign w_p        = i_a ^ i_b;
  assign w_g        = i_a & i_b;
  assign w_blk_c[0] = i_cin;

  // Four 4-bit ripple blocks; a fully propagating block forwards its carry-in directly.
  for (genvar blk = 0; blk < 4; blk++) begin : g_blk
    logic [4:0] w_rc;
    assign w_rc[0] = w_blk_c[blk];
    for (genvar bt = 0; bt < 4; bt++) begin : g_bit
      assign w_rc[bt+1]         = w_g[blk*4+bt] | (w_p[blk*4+bt] & w_rc[bt]);
      assign o_sum[blk*4+bt]    = w_p[blk*4+bt] ^ w_rc[bt];
    end
    assign w_blk_c[blk+1] = (&w_p[blk*4 +: 4]) ? w_blk_c[blk] : w_rc[4];
  end

  assign o_cout = w_blk_c[4];
endmodule

module skip_add_sequencer #(
  parameter int OP_WIDTH    = 64,
  parameter int SLICE_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  skip_add_sequencer_if.slave  bus
);
  localparam int N     = OP_WIDTH / SLICE_WIDTH;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  if ((OP_WIDTH < 16) || ((OP_WIDTH % 16) != 0) || (SLICE_WIDTH != 16)) begin : g_bad_width
    $error("skip_add_sequencer: OP_WIDTH must be a positive multiple of 16 and SLICE_WIDTH 16");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [OP_WIDTH-1:0] r_a;
  logic [OP_WIDTH-1:0] r_b;
  logic [OP_WIDTH-1:0] r_sum;
  logic [IDX_W-1:0]    r_idx;
  logic                r_carry;
  logic                r_cout;
  logic                r_ready;
  logic                r_busy;
  logic                r_done;
  logic [15:0]         w_slice_a;
  logic [15:0]         w_slice_b;
  logic [15:0]         w_slice_sum;
  logic                w_slice_cout;
  logic                w_accept;
  logic                w_last;
  logic [OP_WIDTH-1:0] w_b_load;
  logic                w_c_load;

  assign w_accept  = (r_state == S_IDLE) && bus.start;
  assign w_last    = (r_idx == LAST_IDX);
  assign w_slice_a = r_a[int'(r_idx)*SLICE_WIDTH +: SLICE_WIDTH];
  assign w_slice_b = r_b[int'(r_idx)*SLICE_WIDTH +: SLICE_WIDTH];

`ifdef SKIP_ADD_SEQ_SUB_EN
  // Subtraction as a + ~b + 1; cin is ignored when sub is requested.
  assign w_b_load = bus.sub ? ~bus.b : bus.b;
  assign w_c_load = bus.sub ? 1'b1 : bus.cin;
`else
  assign w_b_load = bus.b;
  assign w_c_load = bus.cin;
`endif

  skip_carry_adder u_adder (
    .i_a    (w_slice_a),
    .i_b    (w_slice_b),
    .i_cin  (r_carry),
    .o_sum  (w_slice_sum),
    .o_cout (w_slice_cout)
  );

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = S_RUN;
        else           w_next = S_IDLE;
      end
      S_RUN: begin
        if (w_last) w_next = S_DONE;
        else        w_next = S_RUN;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register; status flags are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == S_IDLE);
      r_busy  <= (w_next == S_RUN) || (w_next == S_DONE);
      r_done  <= (w_next == S_DONE);
    end
  end

  // Operand capture and slice-by-slice sum assembly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= {OP_WIDTH{1'b0}};
      r_b     <= {OP_WIDTH{1'b0}};
      r_sum   <= {OP_WIDTH{1'b0}};
      r_idx   <= {IDX_W{1'b0}};
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= w_b_load;
            r_carry <= w_c_load;
            r_idx   <= {IDX_W{1'b0}};
          end
        end
        S_RUN: begin
          r_sum[int'(r_idx)*SLICE_WIDTH +: SLICE_WIDTH] <= w_slice_sum;
          r_carry <= w_slice_cout;
          r_idx   <= w_last ? {IDX_W{1'b0}} : r_idx + IDX_W'(1);
          if (w_last) r_cout <= w_slice_cout;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.ready = r_ready;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.sum   = r_sum;
  assign bus.cout  = r_cout;
endmodule

// File: tb/tb_skip_add_sequencer.sv
// Directed, scoreboard-checked bench for skip_add_sequencer (64-bit default).
module tb_skip_add_sequencer;
  localparam int W = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  skip_add_sequencer_if #(.OP_WIDTH(W)) bus ();
  skip_add_sequencer #(.OP_WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int vectors = 0;
  int miscompares = 0;
  logic [W:0] sb_q[$];

  task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic ci, input logic sb);
    if (sb) return {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
    else    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       input logic sb);
    bus.a = a; bus.b = b; bus.cin = ci;
`ifdef SKIP_ADD_SEQ_SUB_EN
    bus.sub = sb;
`endif
    bus.start = 1'b1;
    sb_q.push_back(model(a, b, ci, sb));
  endtask

  task automatic sb_compare(input string tag);
    logic [W:0] exp;
    check({tag, "_sb_pending"}, (sb_q.size() > 0) ? 1 : 0, 1);
    if (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      check({tag, "_sum"}, {1'b0, bus.sum}, {1'b0, exp[W-1:0]});
      check({tag, "_cout"}, bus.cout, exp[W]);
    end
  endtask

  // Called during cycle start_cyc (after the accept edge); waits for done and scores it.
  task automatic wait_done(input string tag, input int start_cyc);
    int cyc = start_cyc;
    logic ok = 1'b1;
    while (bus.done !== 1'b1 && cyc < 30) begin
      if (bus.ready !== 1'b0 || bus.busy !== 1'b1) ok = 1'b0;
      tick();
      cyc++;
    end
    check({tag, "_latency"}, cyc, 5);
    check({tag, "_busy_not_ready"}, ok && bus.ready === 1'b0 && bus.busy === 1'b1, 1);
    sb_compare(tag);
    tick();
    check({tag, "_done_one_cycle"}, bus.done, 0);
    check({tag, "_ready_after"}, bus.ready, 1);
  endtask

  task automatic simple_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic ci, input logic sb);
    drive(a, b, ci, sb);
    tick();
    bus.start = 1'b0;
    bus.a = 64'hDEAD_BEEF_0BAD_F00D;
    bus.b = 64'h1357_9BDF_2468_ACE0;
    bus.cin = ~ci;
    wait_done(tag, 1);
  endtask

  initial begin
    int dn;
    int d[$];
    logic [W:0] exp1;

    rst_n = 1'b0; bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
`ifdef SKIP_ADD_SEQ_SUB_EN
    bus.sub = 1'b0;
`endif
    tick(); tick();
    rst_n = 1'b1;
    check("rst_ready", bus.ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_sum", {1'b0, bus.sum}, 0);
    check("rst_cout", bus.cout, 0);

    simple_op("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    check("wrap_const", {bus.cout, bus.sum}, {1'b1, 64'h0});
    simple_op("slice_carry", 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0);
    check("slice_carry_const", {bus.cout, bus.sum}, {1'b0, 64'h0001_0000_0001_0000});
    simple_op("cin_carry", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
    simple_op("mixed", 64'h8000_7FFF_1234_FFFE, 64'h8000_0001_EDCB_0003, 1'b1, 1'b0);

    // Start while busy is ignored and not queued.
    drive(64'd5, 64'd3, 1'b0, 1'b0);
    tick();
    bus.start = 1'b0; bus.a = 64'd100; bus.b = 64'd100;
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done("ignored_start", 3);
    check("ignored_start_value", {1'b0, bus.sum}, 65'd8);
    dn = 0;
    repeat (8) begin
      tick();
      if (bus.done === 1'b1) dn++;
    end
    check("ignored_start_no_second", dn, 0);

    // Reset mid-operation aborts it.
    bus.a = 64'h1234; bus.b = 64'h1234; bus.cin = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_ready", bus.ready, 1);
    check("abort_busy", bus.busy, 0);
    check("abort_sum", {1'b0, bus.sum}, 0);
    check("abort_cout", bus.cout, 0);
    dn = 0;
    repeat (8) begin
      if (bus.done === 1'b1) dn++;
      tick();
    end
    check("abort_no_done", dn, 0);

    // Back-to-back with start held high; second operands are sampled at the second accept.
    exp1 = model(64'h1, 64'h2, 1'b0, 1'b0);
    drive(64'h1, 64'h2, 1'b0, 1'b0);
    tick();
    drive(64'h0000_0010_FFFF_FFFF, 64'h0000_0020_0000_0001, 1'b1, 1'b0);
    for (int cyc = 1; cyc <= 16; cyc++) begin
      if (bus.done === 1'b1) begin
        d.push_back(cyc);
        sb_compare("b2b");
      end
      if (cyc == 6) check("b2b_sum_hold", {1'b0, bus.sum}, {1'b0, exp1[W-1:0]});
      if (cyc == 7) bus.start = 1'b0;
      tick();
    end
    check("b2b_pulses", d.size(), 2);
    check("b2b_first", (d.size() > 0) ? d[0] : -1, 5);
    check("b2b_second", (d.size() > 1) ? d[1] : -1, 11);

`ifdef SKIP_ADD_SEQ_SUB_EN
    simple_op("sub_neg", 64'd5, 64'd7, 1'b0, 1'b1);
    check("sub_neg_const", {bus.cout, bus.sum}, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
    simple_op("sub_pos", 64'd7, 64'd5, 1'b1, 1'b1);
    check("sub_pos_const", {bus.cout, bus.sum}, {1'b1, 64'h2});
    bus.sub = 1'b0;
`endif

    check("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
